// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch/decode boundary: data width, bubble encoding
// and the occupancy encoding of the IF/ID buffer.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

    // Anything whose low two bits are not 2'b11 is not a 32-bit encoding.
    function automatic logic is_not_32bit(input logic [XLEN-1:0] instr);
        return instr[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running wrap-around event counter with synchronous clear.
module perf_counter #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry (head + skid) FIFO between fetch and decode with flush support.
// Optional performance counters are enabled by defining IF_ID_PERF_EN.
module if_id_buffer
    import riscv_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [XLEN-1:0]   if_instr,
    output logic              if_ready,
    input  logic              flush,
    output logic              id_valid,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_instr,
    output logic              id_illegal,
`ifdef IF_ID_PERF_EN
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_bubble_cycles,
    output logic [PERF_W-1:0] perf_flush_count,
`endif
    input  logic              id_ready
);

    occ_state_t      state_q, state_d;
    logic [XLEN-1:0] head_pc, head_instr;
    logic [XLEN-1:0] skid_pc, skid_instr;
    logic            accept, emit;

    // Both handshakes depend only on the registered occupancy.
    assign if_ready = (state_q != FULL);
    assign id_valid = (state_q != EMPTY);
    assign accept   = if_valid & if_ready;
    assign emit     = id_valid & id_ready;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) state_d = HALF;
                HALF: begin
                    if (accept && !emit)
                        state_d = FULL;
                    else if (emit && !accept)
                        state_d = EMPTY;
                end
                FULL:  if (emit) state_d = HALF;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Head always holds the oldest beat; skid only fills when head is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_pc    <= '0;
            head_instr <= NOP_INSTR;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
        end else if (!flush) begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_pc    <= if_pc;
                        head_instr <= if_instr;
                    end
                end
                HALF: begin
                    if (accept && emit) begin
                        head_pc    <= if_pc;
                        head_instr <= if_instr;
                    end else if (accept) begin
                        skid_pc    <= if_pc;
                        skid_instr <= if_instr;
                    end
                end
                FULL: begin
                    if (emit) begin
                        head_pc    <= skid_pc;
                        head_instr <= skid_instr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign id_pc      = id_valid ? head_pc    : '0;
    assign id_instr   = id_valid ? head_instr : NOP_INSTR;
    assign id_illegal = id_valid & is_not_32bit(head_instr);

`ifdef IF_ID_PERF_EN
    perf_counter #(.PERF_W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (if_valid & ~if_ready),
        .count (perf_stall_cycles)
    );

    perf_counter #(.PERF_W(PERF_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (id_ready & ~id_valid),
        .count (perf_bubble_cycles)
    );

    perf_counter #(.PERF_W(PERF_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush),
        .count (perf_flush_count)
    );
`endif

endmodule
